gpio_irq_ctrl: RTL
==================

Name: gpio_irq_ctrl

Overview:
Input-side companion to the GPIO pad/register block. It consumes the raw pad input vector (gpio_i) and applies, per pin:
- synchronisation into apb_pclk;
- a programmable debounce filter;
- edge or level interrupt detection.

Pending status is exposed on the same APB slave bus, in a register window disjoint from the GPIO output registers. A single aggregated interrupt line goes to the CPU interrupt controller.

Parameters:
NPIN, 32, number of input pins handled (1..32).
SYNC_STAGES, 2, synchroniser flop depth (>=2).
DB_W, 8, debounce counter width per pin.

Ports:
apb_pclk  in  1  APB clock; all logic on rising edge.
apb_prstn  in  1  asynchronous, active-low reset.
apb_psel  in  1  APB select.
apb_paddr  in  32  APB address; only [7:0] decoded.
apb_pwrite  in  1  APB write strobe.
apb_penable  in  1  APB access phase.
apb_pwdata  in  32  APB write data.
apb_prdata  out  32  APB read data.
gpio_i  in  NPIN  raw pad inputs (asynchronous).
gpio_sync  out  NPIN  debounced, synchronised pin values.
irq  out  1  aggregated interrupt, active high.

Behaviour:
Register map, paddr[7:0]:
- 0x60 IRQ_EN (RW): per-pin enable.
- 0x64 IRQ_TYPE (RW): 0 = edge, 1 = level.
- 0x68 IRQ_POL (RW): edge mode 0 = rising, 1 = falling; level mode 0 = high, 1 = low.
- 0x6C IRQ_BOTH (RW): edge mode only; 1 = any edge, overrides POL.
- 0x70 IRQ_PEND (R/W1C).
- 0x74 DB_CNT (RW, bits [DB_W-1:0], upper bits read 0).
- 0x78 PIN_VAL (RO) = gpio_sync.

APB bus rules:
- Write occurs when psel & penable & pwrite, taking effect at that clock edge.
- Read is combinational: apb_prdata = selected register when psel & penable & ~pwrite, else 0.
- Unmapped offsets read 0; writes to them are ignored.
- No wait states.
- Bits at or above NPIN read 0 and are not writable.

Synchroniser:
- gpio_i passes through SYNC_STAGES flops per pin to give s.

Debounce, per pin (filtered value f, counter c):
- If s == f: c <= 0.
- Else if c == DB_CNT: f <= s, c <= 0.
- Else: c <= c+1.
- f must see s different from f for DB_CNT+1 consecutive cycles before it changes; any bounce back restarts the count.
- DB_CNT=0: f follows s one cycle later.
- gpio_sync = f.
- Total latency gpio_i change to gpio_sync = SYNC_STAGES + DB_CNT + 1 cycles (3 with defaults and DB_CNT=0).
- A DB_CNT write takes effect immediately. Counters are not cleared. If c > new DB_CNT, the pin does not update until c wraps (documented, legal).

Detection:
- fp <= f every cycle.
- rise = f & ~fp; fall = ~f & fp.
- ev = TYPE ? (f ^ POL) : (BOTH ? rise|fall : POL ? fall : rise).

Pending:
- PEND[i] <= (PEND[i] & ~w1c[i]) | (ev[i] & EN[i]).
- Set wins over a simultaneous W1C.
- Level mode: W1C while the level is still asserted leaves PEND set.
- Clearing EN does not clear PEND.

Interrupt:
- irq = |(PEND & EN), driven from flops only (glitch-free).
- Pending appears 1 cycle after the f edge; irq is asserted in the same cycle as PEND.

Reset (async, apb_prstn low):
- All registers, sync flops, f, fp and c go to 0.
- gpio_sync = 0, irq = 0, apb_prdata = 0.
- Reset mid-debounce discards the count.
- After reset release, a pin held high produces a rising event, but it is not latched because EN = 0.

Test Plan:
- Reset with gpio_i=all ones -> gpio_sync=0, irq=0. After release, gpio_sync=all ones by cycle 3; PEND reads 0x0.
- EN=0x1, TYPE=0, POL=0, DB_CNT=0; gpio_i[0] 0->1 -> PEND=0x1 and irq=1 four cycles after the input change. Write 0x70 with 0x1 -> PEND=0, irq=0 next cycle.
- DB_CNT=5; pulse gpio_i[3] high for 4 cycles -> gpio_sync[3] stays 0, no pending. Hold high 7 cycles -> gpio_sync[3]=1 at cycle 8 after the edge.
- TYPE[2]=1, POL[2]=1, EN[2]=1, gpio_i[2]=0 held -> PEND[2]=1; W1C has no effect. Set gpio_i[2]=1, then W1C -> PEND[2]=0.
- BOTH[5]=1, EN[5]=1; toggle gpio_i[5] 0->1->0, clearing PEND between edges -> PEND[5] sets on each edge. W1C in the same cycle as a new edge -> PEND[5] remains 1.
- Read 0x7C, and write 0x7C with 0xFFFFFFFF -> reads 0, no register changes. Read with apb_pwrite=1 -> apb_prdata=0.

Source files
------------

// File: rtl/gpio_irq_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_irq_ctrl
//   Input-side GPIO companion: per-pin synchroniser, debounce filter and
//   edge/level interrupt detection, with pending status and configuration
//   on an APB slave window (0x60..0x78). One aggregated interrupt output.
//
// Ports
//   apb_pclk, apb_prstn        clock, async active-low reset
//   apb_psel/penable/pwrite    APB control (no wait states)
//   apb_paddr, apb_pwdata      APB address (only [7:0] decoded), write data
//   apb_prdata                 combinational read data (0 when not reading)
//   gpio_i                     raw asynchronous pad inputs
//   gpio_sync                  synchronised, debounced pin values
//   irq                        |(PEND & EN), registered
// ---------------------------------------------------------------------------

// Per-pin datapath: synchroniser, debounce filter, event detector.
module gpio_irq_pin #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_W        = 8
) (
   input  logic            apb_pclk,
   input  logic            apb_prstn,
   input  logic            pin_i,
   input  logic [DB_W-1:0] db_cnt_i,
   input  logic            type_i,
   input  logic            pol_i,
   input  logic            both_i,
   output logic            f_o,
   output logic            ev_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [DB_W-1:0]        c_q, c_d;
   logic                   f_q, f_d;
   logic                   fp_q;
   logic                   s;
   logic                   rise, fall;

   assign s = sync_q[SYNC_STAGES-1];

   // Counter runs only while s disagrees with f; a bounce back clears it.
   // If DB_CNT is lowered below the current count, c simply wraps first.
   always_comb begin
      f_d = f_q;
      c_d = '0;
      if (s != f_q) begin
         if (c_q == db_cnt_i) f_d = s;
         else                 c_d = c_q + 1'b1;
      end
   end

   always_ff @(posedge apb_pclk or negedge apb_prstn) begin
      if (!apb_prstn) begin
         sync_q <= '0;
         c_q    <= '0;
         f_q    <= 1'b0;
         fp_q   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
         c_q    <= c_d;
         f_q    <= f_d;
         fp_q   <= f_q;
      end
   end

   assign rise = f_q & ~fp_q;
   assign fall = ~f_q & fp_q;
   assign f_o  = f_q;
   assign ev_o = type_i ? (f_q ^ pol_i)
                        : (both_i ? (rise | fall) : (pol_i ? fall : rise));

endmodule

module gpio_irq_ctrl #(
   parameter int NPIN        = 32,
   parameter int SYNC_STAGES = 2,
   parameter int DB_W        = 8
) (
   input  logic            apb_pclk,
   input  logic            apb_prstn,
   input  logic            apb_psel,
   input  logic [31:0]     apb_paddr,
   input  logic            apb_pwrite,
   input  logic            apb_penable,
   input  logic [31:0]     apb_pwdata,
   output logic [31:0]     apb_prdata,
   input  logic [NPIN-1:0] gpio_i,
   output logic [NPIN-1:0] gpio_sync,
   output logic            irq
);

   localparam logic [7:0] A_EN   = 8'h60;
   localparam logic [7:0] A_TYPE = 8'h64;
   localparam logic [7:0] A_POL  = 8'h68;
   localparam logic [7:0] A_BOTH = 8'h6C;
   localparam logic [7:0] A_PEND = 8'h70;
   localparam logic [7:0] A_DB   = 8'h74;
   localparam logic [7:0] A_VAL  = 8'h78;

   logic [NPIN-1:0] en_q, en_d, type_q, type_d, pol_q, pol_d, both_q, both_d;
   logic [NPIN-1:0] pend_q, pend_d, w1c, ev;
   logic [DB_W-1:0] db_q, db_d;
   logic            irq_q;
   logic            wr, rd;
   logic [7:0]      addr;
   logic [NPIN-1:0] wdat;
   logic            unused_ok;

   assign addr      = apb_paddr[7:0];
   assign wdat      = apb_pwdata[NPIN-1:0];
   assign wr        = apb_psel & apb_penable & apb_pwrite;
   assign rd        = apb_psel & apb_penable & ~apb_pwrite;
   assign unused_ok = ^{apb_paddr[31:8], apb_pwdata};

   gpio_irq_pin #(.SYNC_STAGES(SYNC_STAGES), .DB_W(DB_W)) u_pin [NPIN-1:0] (
      .apb_pclk  (apb_pclk),
      .apb_prstn (apb_prstn),
      .pin_i     (gpio_i),
      .db_cnt_i  (db_q),
      .type_i    (type_q),
      .pol_i     (pol_q),
      .both_i    (both_q),
      .f_o       (gpio_sync),
      .ev_o      (ev)
   );

   always_comb begin
      en_d   = en_q;
      type_d = type_q;
      pol_d  = pol_q;
      both_d = both_q;
      db_d   = db_q;
      w1c    = '0;
      if (wr) begin
         case (addr)
            A_EN:    en_d   = wdat;
            A_TYPE:  type_d = wdat;
            A_POL:   pol_d  = wdat;
            A_BOTH:  both_d = wdat;
            A_PEND:  w1c    = wdat;
            A_DB:    db_d   = apb_pwdata[DB_W-1:0];
            default: ;
         endcase
      end
      // OR-ing the set term last makes a new event win over a same-cycle W1C.
      pend_d = (pend_q & ~w1c) | (ev & en_q);
   end

   always_ff @(posedge apb_pclk or negedge apb_prstn) begin
      if (!apb_prstn) begin
         en_q   <= '0;
         type_q <= '0;
         pol_q  <= '0;
         both_q <= '0;
         pend_q <= '0;
         db_q   <= '0;
         irq_q  <= 1'b0;
      end else begin
         en_q   <= en_d;
         type_q <= type_d;
         pol_q  <= pol_d;
         both_q <= both_d;
         pend_q <= pend_d;
         db_q   <= db_d;
         // Registered from next-state so irq tracks PEND in the same cycle
         // while leaving the output free of combinational glitches.
         irq_q  <= |(pend_d & en_d);
      end
   end

   assign irq = irq_q;

   always_comb begin
      apb_prdata = '0;
      if (rd) begin
         case (addr)
            A_EN:    apb_prdata = 32'(en_q);
            A_TYPE:  apb_prdata = 32'(type_q);
            A_POL:   apb_prdata = 32'(pol_q);
            A_BOTH:  apb_prdata = 32'(both_q);
            A_PEND:  apb_prdata = 32'(pend_q);
            A_DB:    apb_prdata = 32'(db_q);
            A_VAL:   apb_prdata = 32'(gpio_sync);
            default: apb_prdata = '0;
         endcase
      end
   end

endmodule
